da_lut_loader: RTL and testbench

Precompute-and-load engine that sits directly upstream of `fir_filter`. It holds the 64 filter coefficients and generates the 2048-entry distributed-arithmetic partial-sum LUT: 8 groups of 8 taps, 256 entries per group. It streams that LUT into the filter's `CIN`/`CADDR`/`CLOAD` port. This replaces software LUT precompute and gives the filter a hardware coefficient-update path.

---
 rtl/da_lut_pkg.sv | 21 ++
 rtl/da_coef_regfile.sv | 34 +++
 rtl/da_lut_loader.sv | 170 +++++++++++++++++
 tb/tb_da_lut_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/da_lut_pkg.sv
// Shared constants and FSM state encoding for the distributed-arithmetic
// LUT loader that feeds fir_filter.
package da_lut_pkg;

  localparam int COEF_W     = 16;
  localparam int GROUP_SIZE = 8;
  localparam int NUM_GROUPS = 8;
  localparam int LUT_W      = COEF_W + 3;
  localparam int ADDR_W     = 11;
  localparam int NUM_TAPS   = NUM_GROUPS * GROUP_SIZE;

  localparam logic [ADDR_W-1:0] LAST_ADDR = 11'd2047;

  // Kept as plain constants so older tools that mishandle enums still parse.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ACC  = 2'd1;
  localparam state_t EMIT = 2'd2;
  localparam state_t DONE = 2'd3;

endpackage

// File: rtl/da_coef_regfile.sv
// Coefficient store: one synchronous write port, one combinational read
// port, cleared by synchronous reset.
module da_coef_regfile
  import da_lut_pkg::*;
#(
  parameter int DATA_W = COEF_W,
  parameter int DEPTH  = NUM_TAPS,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [AW-1:0]            raddr,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] regs [DEPTH];

  // Write port with whole-array clear.
  // NOTE: the array has to read back as zero after reset, so it is built
  // from resettable flops; a RAM macro could not honour the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];

endmodule

// File: rtl/da_lut_loader.sv
// Distributed-arithmetic LUT generator and loader for fir_filter.
// Entry {g, s} is the sum of the coefficients of group g whose select bit
// in s is set. Each entry takes 8 accumulate cycles plus one emit cycle.
// Optional feature: define DA_LUT_LOADER_CHECKSUM_EN to add the
// lut_checksum output (running sum of every transferred entry).
module da_lut_loader #(
  parameter int COEF_W     = da_lut_pkg::COEF_W,
  parameter int GROUP_SIZE = da_lut_pkg::GROUP_SIZE,
  parameter int NUM_GROUPS = da_lut_pkg::NUM_GROUPS,
  parameter int LUT_W      = COEF_W + 3,
  parameter int ADDR_W     = $clog2(NUM_GROUPS) + GROUP_SIZE
) (
  input  logic                                        clk_slow,
  input  logic                                        reset,
  input  logic                                        coef_we,
  input  logic [$clog2(NUM_GROUPS*GROUP_SIZE)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]                    coef_data,
  input  logic                                        start,
  output logic                                        busy,
  output logic                                        done,
  output logic signed [LUT_W-1:0]                     lut_cin,
  output logic [ADDR_W-1:0]                           lut_caddr,
  output logic                                        lut_cload,
  output logic                                        lut_valid,
  input  logic                                        lut_ready
`ifdef DA_LUT_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]                                 lut_checksum
`endif
);

  import da_lut_pkg::state_t;
  import da_lut_pkg::IDLE;
  import da_lut_pkg::ACC;
  import da_lut_pkg::EMIT;
  import da_lut_pkg::DONE;

  localparam int NUM_TAPS = NUM_GROUPS * GROUP_SIZE;
  localparam int TAP_W    = $clog2(NUM_TAPS);
  localparam int BIT_W    = $clog2(GROUP_SIZE);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_GROUPS * (2 ** GROUP_SIZE) - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(GROUP_SIZE - 1);

  state_t                   state;
  logic [BIT_W-1:0]         bit_idx;
  logic [ADDR_W-1:0]        addr;
  logic signed [LUT_W-1:0]  acc;

  logic                     coef_wr;
  logic                     start_ok;
  logic                     xfer;
  logic                     sel_bit;
  logic [TAP_W-1:0]         rd_tap;
  logic signed [COEF_W-1:0] coef_rd;
  logic signed [LUT_W-1:0]  coef_ext;

  // Coefficients may only change while idle; a write in the same cycle as
  // start lands before the first accumulate cycle reads it.
  assign coef_wr  = coef_we && (state == IDLE);
  assign start_ok = start && (state == IDLE);
  assign xfer     = (state == EMIT) && lut_ready;

  // The tap for the current step is {group, bit}; the select bit comes
  // from the low GROUP_SIZE bits of the entry address.
  assign rd_tap   = {addr[ADDR_W-1:GROUP_SIZE], bit_idx};
  assign sel_bit  = addr[bit_idx];
  assign coef_ext = {{(LUT_W-COEF_W){coef_rd[COEF_W-1]}}, coef_rd};

  da_coef_regfile #(
    .DATA_W (COEF_W),
    .DEPTH  (NUM_TAPS)
  ) u_coef (
    .clk   (clk_slow),
    .reset (reset),
    .we    (coef_wr),
    .waddr (coef_addr),
    .wdata (coef_data),
    .raddr (rd_tap),
    .rdata (coef_rd)
  );

  // Sequencer: accumulate one select bit per cycle, then hold the entry
  // until the sink takes it.
  // NOTE: state registers use non-blocking assignments so every flop sees
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk_slow) begin
    if (reset) begin
      state   <= IDLE;
      bit_idx <= '0;
      addr    <= '0;
      acc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ACC;
            bit_idx <= '0;
            addr    <= '0;
            acc     <= '0;
          end
        end
        ACC: begin
          if (sel_bit) acc <= acc + coef_ext;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == LAST_BIT) state <= EMIT;
        end
        EMIT: begin
          if (lut_ready) begin
            if (addr == LAST) begin
              state <= DONE;
            end else begin
              state   <= ACC;
              addr    <= addr + 1'b1;
              acc     <= '0;
              bit_idx <= '0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status and handshake outputs decoded from the state register.
  // NOTE: every output gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    busy      = 1'b0;
    lut_cload = 1'b0;
    lut_valid = 1'b0;
    done      = 1'b0;
    case (state)
      ACC: begin
        busy      = 1'b1;
        lut_cload = 1'b1;
      end
      EMIT: begin
        busy      = 1'b1;
        lut_cload = 1'b1;
        lut_valid = 1'b1;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // The accumulator and address registers double as the output registers;
  // they only change on a transfer, so they are stable under backpressure.
  assign lut_cin   = acc;
  assign lut_caddr = addr;

`ifdef DA_LUT_LOADER_CHECKSUM_EN
  // Running sum of every entry handed to the filter, restarted per load.
  always_ff @(posedge clk_slow) begin
    if (reset) begin
      lut_checksum <= '0;
    end else if (start_ok) begin
      lut_checksum <= '0;
    end else if (xfer) begin
      lut_checksum <= lut_checksum + {{(32-LUT_W){acc[LUT_W-1]}}, acc};
    end
  end
`endif

endmodule

// File: tb/tb_da_lut_loader.sv
// Self-checking bench for da_lut_loader. Expected entries come from a
// coefficient array and a direct evaluation of the DA sum for each address.
module tb_da_lut_loader;

  logic               clk_slow = 1'b0;
  logic               reset;
  logic               coef_we;
  logic [5:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic               start;
  logic               busy;
  logic               done;
  logic signed [18:0] lut_cin;
  logic [10:0]        lut_caddr;
  logic               lut_cload;
  logic               lut_valid;
  logic               lut_ready;
`ifdef DA_LUT_LOADER_CHECKSUM_EN
  logic [31:0]        lut_checksum;
`endif

  int checks = 0;
  int errors = 0;

  int                 model_coef [64];
  logic signed [18:0] got [2048];

  da_lut_loader dut (
    .clk_slow  (clk_slow),
    .reset     (reset),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .lut_cin   (lut_cin),
    .lut_caddr (lut_caddr),
    .lut_cload (lut_cload),
    .lut_valid (lut_valid),
    .lut_ready (lut_ready)
`ifdef DA_LUT_LOADER_CHECKSUM_EN
    ,
    .lut_checksum (lut_checksum)
`endif
  );

  always #5 clk_slow = ~clk_slow;

  // Reference: entry {g, s} = sum of coef[g*8+b] for each set bit b of s.
  function automatic int ref_entry(input int a);
    int g = a / 256;
    int s = a % 256;
    int sum = 0;
    for (int b = 0; b < 8; b++)
      if (((s >> b) & 1) == 1) sum += model_coef[g*8 + b];
    return sum;
  endfunction

  task automatic load_coef(input int k, input int v);
    coef_we   = 1'b1;
    coef_addr = 6'(k);
    coef_data = 16'(v);
    model_coef[k] = v;
    @(posedge clk_slow); #1;
    coef_we = 1'b0;
  endtask

  // Runs one full generation, checking every entry, its arrival time, the
  // control outputs each cycle, and the done timing. Optional: stall one
  // entry, abort with reset at an entry, inject busy-time writes/starts,
  // and write a coefficient in the same cycle as start.
  task automatic run_lut(input string name, input int stall_entry, input int stall_len,
                         input int abort_entry, input bit inject,
                         input int wr_addr, input int wr_data);
    int idx = 0, edge_cnt = 0, xfers = 0, stall_left = stall_len;
    int exp_edge, done_edge = -1, exp_val, exp_sum = 0;
    bit pending = 0, seen = 0, finished = 0, aborted = 0;
    start = 1'b1;
    lut_ready = 1'b1;
    if (wr_addr >= 0) begin
      coef_we   = 1'b1;
      coef_addr = 6'(wr_addr);
      coef_data = 16'(wr_data);
      model_coef[wr_addr] = wr_data;
    end
    for (int a = 0; a < 2048; a++) exp_sum += ref_entry(a);
    @(posedge clk_slow); #1;
    start = 1'b0;
    coef_we = 1'b0;
    checks++;
    if (busy !== 1'b1 || lut_cload !== 1'b1 || lut_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: busy=%b cload=%b valid=%b done=%b, required 1 1 0 0",
               name, busy, lut_cload, lut_valid, done);
    end
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(posedge clk_slow); edge_cnt++; #1;
      start = 1'b0;
      coef_we = 1'b0;
      if (pending) begin
        pending = 0;
        xfers++;
        idx++;
      end
      checks++;
      if (busy !== (xfers < 2048) || lut_cload !== (xfers < 2048) || done !== (xfers == 2048)) begin
        errors++;
        if (errors <= 20)
          $display("FAIL %s ctrl at E%0d: busy=%b cload=%b done=%b after %0d transfers",
                   name, edge_cnt, busy, lut_cload, done, xfers);
      end
      if (xfers == 2048) begin
        finished = 1;
        done_edge = edge_cnt;
        break;
      end
      if (inject && edge_cnt == 50) begin
        coef_we   = 1'b1;
        coef_addr = 6'd0;
        coef_data = 16'sd7;
        start     = 1'b1;
      end
      if (lut_valid) begin
        if (!seen) begin
          seen = 1;
          exp_edge = 8 + 9*idx + ((stall_entry >= 0 && idx > stall_entry) ? stall_len : 0);
          checks++;
          if (edge_cnt !== exp_edge) begin
            errors++;
            if (errors <= 20)
              $display("FAIL %s timing entry %0d: valid after E%0d, required E%0d",
                       name, idx, edge_cnt, exp_edge);
          end
          if (idx == abort_entry) begin
            reset = 1'b1;
            aborted = 1;
            break;
          end
        end
        exp_val = ref_entry(idx);
        checks++;
        if (lut_caddr !== 11'(idx)) begin
          errors++;
          if (errors <= 20)
            $display("FAIL %s caddr entry %0d: got %0d required %0d", name, idx, lut_caddr, idx);
        end
        checks++;
        if (int'(lut_cin) !== exp_val) begin
          errors++;
          if (errors <= 20)
            $display("FAIL %s cin entry %0d: got %0d required %0d", name, idx, lut_cin, exp_val);
        end
        got[idx] = lut_cin;
        if (idx == stall_entry && stall_left > 0) begin
          lut_ready = 1'b0;
          stall_left--;
        end else begin
          lut_ready = 1'b1;
          pending = 1;
          seen = 0;
        end
      end else begin
        lut_ready = 1'($urandom_range(0, 1));
      end
    end

    if (aborted) begin
      @(posedge clk_slow); #1;
      reset = 1'b0;
      lut_ready = 1'b0;
      for (int k = 0; k < 64; k++) model_coef[k] = 0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || lut_valid !== 1'b0 || lut_cload !== 1'b0 ||
          lut_cin !== 19'sd0 || lut_caddr !== 11'd0) begin
        errors++;
        $display("FAIL %s abort outputs: busy=%b done=%b valid=%b cload=%b cin=%0d caddr=%0d, required all 0",
                 name, busy, done, lut_valid, lut_cload, lut_cin, lut_caddr);
      end
`ifdef DA_LUT_LOADER_CHECKSUM_EN
      checks++;
      if (lut_checksum !== 32'd0) begin
        errors++;
        $display("FAIL %s abort checksum: got %0d required 0", name, lut_checksum);
      end
`endif
      repeat (3) begin
        @(posedge clk_slow); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s abort no-done: done=%b busy=%b required 0 0", name, done, busy);
        end
      end
      return;
    end

    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: %0d transfers seen, required 2048", name, xfers);
    end else if (done_edge !== 18432 + ((stall_entry >= 0) ? stall_len : 0)) begin
      errors++;
      $display("FAIL %s done edge: got E%0d required E%0d", name, done_edge,
               18432 + ((stall_entry >= 0) ? stall_len : 0));
    end
    @(posedge clk_slow); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || lut_cload !== 1'b0 || lut_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s post-done: done=%b busy=%b cload=%b valid=%b required 0 0 0 0",
               name, done, busy, lut_cload, lut_valid);
    end
`ifdef DA_LUT_LOADER_CHECKSUM_EN
    checks++;
    if (lut_checksum !== 32'(exp_sum)) begin
      errors++;
      $display("FAIL %s checksum: got %0d required %0d", name, $signed(lut_checksum), exp_sum);
    end
`endif
    lut_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    lut_ready = 1'b0;
    for (int k = 0; k < 64; k++) model_coef[k] = 0;
    repeat (3) @(posedge clk_slow);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || lut_valid !== 1'b0 || lut_cload !== 1'b0) begin
      errors++;
      $display("FAIL reset ctrl: busy=%b done=%b valid=%b cload=%b required 0 0 0 0",
               busy, done, lut_valid, lut_cload);
    end
    checks++;
    if (lut_cin !== 19'sd0 || lut_caddr !== 11'd0) begin
      errors++;
      $display("FAIL reset data: cin=%0d caddr=%0d required 0 0", lut_cin, lut_caddr);
    end
`ifdef DA_LUT_LOADER_CHECKSUM_EN
    checks++;
    if (lut_checksum !== 32'd0) begin
      errors++;
      $display("FAIL reset checksum: got %0d required 0", lut_checksum);
    end
`endif
    reset = 1'b0;
    @(posedge clk_slow); #1;
  endtask

  task automatic test_reset_mid_run;
    for (int k = 0; k < 64; k++) load_coef(k, k + 1);
    run_lut("abort", -1, 0, 100, 0, -1, 0);
  endtask

  // Runs straight after the abort, so zero entries also prove the clear.
  task automatic test_all_zero;
    run_lut("zero", -1, 0, -1, 0, -1, 0);
    checks++;
    if (got[2047] !== 19'sd0 || got[0] !== 19'sd0) begin
      errors++;
      $display("FAIL zero ends: entry0=%0d entry2047=%0d required 0 0", got[0], got[2047]);
    end
  endtask

  task automatic test_ramp;
    for (int k = 0; k < 63; k++) load_coef(k, k + 1);
    run_lut("ramp", -1, 0, -1, 1, 63, 64);
    checks++;
    if (int'(got[12'h0FF]) !== 36) begin
      errors++;
      $display("FAIL ramp 0x0FF: got %0d required 36", got[12'h0FF]);
    end
    checks++;
    if (int'(got[12'h105]) !== 20) begin
      errors++;
      $display("FAIL ramp 0x105: got %0d required 20", got[12'h105]);
    end
    checks++;
    if (int'(got[12'h780]) !== 64) begin
      errors++;
      $display("FAIL ramp 0x780 (write with start): got %0d required 64", got[12'h780]);
    end
`ifdef DA_LUT_LOADER_CHECKSUM_EN
    checks++;
    if (lut_checksum !== 32'd266240) begin
      errors++;
      $display("FAIL ramp checksum: got %0d required 266240", lut_checksum);
    end
`endif
  endtask

  // Same coefficients as the ramp run: entry 1 must still show coef[0] = 1
  // even though tap 0 was written with 7 while busy.
  task automatic test_backpressure;
    run_lut("stall", 3, 5, -1, 0, -1, 0);
    checks++;
    if (int'(got[1]) !== 1) begin
      errors++;
      $display("FAIL busy write leaked: entry1 got %0d required 1", got[1]);
    end
  endtask

  task automatic test_extremes;
    logic signed [15:0] r;
    int v;
    for (int k = 0; k < 64; k++) begin
      r = 16'($urandom);
      if (k / 8 < 3) v = 32767;
      else if (k / 8 > 5) v = -32768;
      else v = int'(r);
      load_coef(k, v);
    end
    run_lut("extreme", int'($urandom_range(0, 2047)), int'($urandom_range(1, 6)), -1, 0, -1, 0);
    checks++;
    if (int'(got[12'h0FF]) !== 262136) begin
      errors++;
      $display("FAIL max 0x0FF: got %0d required 262136", got[12'h0FF]);
    end
    checks++;
    if (int'(got[12'h7FF]) !== -262144) begin
      errors++;
      $display("FAIL min 0x7FF: got %0d required -262144", got[12'h7FF]);
    end
    checks++;
    if (int'(got[12'h100]) !== 0 || int'(got[12'h700]) !== 0) begin
      errors++;
      $display("FAIL empty select: 0x100=%0d 0x700=%0d required 0 0", got[12'h100], got[12'h700]);
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_run;
    test_all_zero;
    test_ramp;
    test_backpressure;
    test_extremes;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
